// File: rtl/fabric_config_loader.sv
// Byte-stream configuration loader for fabric_2x2: assembles a frame into a shadow
// register, verifies its XOR checksum, commits atomically and holds the fabric in reset.
module fabric_config_loader #(
    parameter int CFG_W      = 52,
    parameter int NBYTES     = (CFG_W + 7) / 8,
    parameter int RST_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             cfg_abort,
    output logic [CFG_W-1:0] config_bits,
    output logic             fabric_rst_n,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int SH_W   = $clog2(CFG_W);

    // s_valid/s_ready: a byte transfers in every cycle where both are high at the
    // rising edge; s_ready is high exactly while the FSM sits in LOAD.
    typedef enum logic [1:0] {
        S_LOAD,
        S_CHECK,
        S_HOLD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         acc;
    logic [7:0]         chk;
    logic [CFG_W-1:0]   shadow;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               hs;

    assign hs       = s_valid && s_ready;
    assign cfg_busy = (state != S_LOAD) || (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_HOLD;
            cnt          <= '0;
            acc          <= '0;
            chk          <= '0;
            shadow       <= '0;
            config_bits  <= '0;
            hold_cnt     <= HOLD_W'(RST_CYCLES);
            s_ready      <= 1'b0;
            fabric_rst_n <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (cfg_abort) begin
                        cnt <= '0;
                        acc <= '0;
                    end else if (hs) begin
                        if (cnt == CNT_W'(NBYTES)) begin
                            chk     <= s_data;
                            cnt     <= '0;
                            state   <= S_CHECK;
                            s_ready <= 1'b0;
                        end else begin
                            acc <= acc ^ s_data;
                            cnt <= cnt + 1'b1;
                            // Bits of the last byte beyond CFG_W have no shadow slot and fall away here.
                            for (int b = 0; b < CFG_W; b++) begin
                                if (cnt == CNT_W'(b / 8))
                                    shadow[SH_W'(b)] <= s_data[3'(b % 8)];
                            end
                        end
                    end
                end
                S_CHECK: begin
                    acc <= '0;
                    cnt <= '0;
                    if (cfg_abort) begin
                        state   <= S_LOAD;
                        s_ready <= 1'b1;
                    end else if (chk == acc) begin
                        config_bits  <= shadow;
                        hold_cnt     <= HOLD_W'(RST_CYCLES);
                        state        <= S_HOLD;
                        cfg_done     <= 1'b1;
                        fabric_rst_n <= 1'b0;
                    end else begin
                        cfg_err <= 1'b1;
                        state   <= S_LOAD;
                        s_ready <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt <= HOLD_W'(1)) begin
                        state        <= S_LOAD;
                        s_ready      <= 1'b1;
                        fabric_rst_n <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state        <= S_HOLD;
                    hold_cnt     <= HOLD_W'(RST_CYCLES);
                    s_ready      <= 1'b0;
                    fabric_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed and randomized frames for fabric_config_loader, checked against a
// frame-level model (byte concatenation, XOR rule, fixed reset-hold length).
module tb_fabric_config_loader;

    localparam int CFG_W      = 52;
    localparam int NBYTES     = 7;
    localparam int RST_CYCLES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_ready;
    logic             cfg_abort;
    logic [CFG_W-1:0] config_bits;
    logic             fabric_rst_n;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;

    fabric_config_loader #(
        .CFG_W(CFG_W),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .cfg_abort(cfg_abort),
        .config_bits(config_bits),
        .fabric_rst_n(fabric_rst_n),
        .cfg_busy(cfg_busy),
        .cfg_done(cfg_done),
        .cfg_err(cfg_err)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    // scoreboard state
    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int err_seen = 0;
    int exp_done = 0;
    int exp_err = 0;
    logic [CFG_W-1:0] exp_q[$];
    logic [CFG_W-1:0] model_cfg;
    logic [7:0]       frm[NBYTES+1];

    always @(negedge clk) begin
        if (cfg_done === 1'b1) done_seen++;
        if (cfg_err === 1'b1) err_seen++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference model: frame value is the little-endian byte concatenation cut to CFG_W
    function automatic logic [CFG_W-1:0] frame_value();
        logic [8*NBYTES-1:0] v;
        v = '0;
        for (int i = 0; i < NBYTES; i++) v = v | ((8*NBYTES)'(frm[i]) << (8 * i));
        return v[CFG_W-1:0];
    endfunction

    function automatic bit frame_good();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < NBYTES; i++) x = x ^ frm[i];
        return x == frm[NBYTES];
    endfunction

    // driver tasks (all entered and left at a falling edge)
    task automatic send_byte(input logic [7:0] b, input bit throttle);
        bit took;
        took = 1'b0;
        if (throttle) begin
            repeat ($urandom_range(0, 3)) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int t = 0; t < 64 && !took; t++) begin
            took = s_ready;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        check("handshake", 64'(took), 64'd1);
    endtask

    task automatic send_frame(input bit throttle);
        for (int i = 0; i <= NBYTES; i++) send_byte(frm[i], throttle);
    endtask

    task automatic measure_hold(input bit poke_abort, output int n, output int dones);
        n = 0;
        dones = 0;
        for (int t = 0; t < 32; t++) begin
            if (fabric_rst_n !== 1'b0) break;
            n++;
            if (cfg_done === 1'b1) dones++;
            if (poke_abort && t == 1) cfg_abort = 1'b1;
            @(negedge clk);
            cfg_abort = 1'b0;
        end
    endtask

    // called in the CHECK cycle, right after the checksum handshake
    task automatic finish_frame(input bit poke_abort);
        int n;
        int dones;
        check("check_ready", 64'(s_ready), 64'd0);
        check("check_busy", 64'(cfg_busy), 64'd1);
        if (frame_good()) begin
            exp_q.push_back(frame_value());
            exp_done++;
            @(negedge clk);
            model_cfg = exp_q.pop_front();
            check("commit_value", 64'(config_bits), 64'(model_cfg));
            check("done_pulse", 64'(cfg_done), 64'd1);
            measure_hold(poke_abort, n, dones);
            check("hold_len", 64'(n), 64'(RST_CYCLES));
            check("done_once", 64'(dones), 64'd1);
            check("ready_after_hold", 64'(s_ready), 64'd1);
            check("idle_after_hold", 64'(cfg_busy), 64'd0);
        end else begin
            exp_err++;
            @(negedge clk);
            check("err_pulse", 64'(cfg_err), 64'd1);
            check("err_ready", 64'(s_ready), 64'd1);
            check("err_fabric_rst_n", 64'(fabric_rst_n), 64'd1);
            check("err_keeps_cfg", 64'(config_bits), 64'(model_cfg));
            @(negedge clk);
            check("err_once", 64'(cfg_err), 64'd0);
        end
    endtask

    task automatic do_reset(input int cycles);
        int n;
        int dones;
        rst       = 1'b1;
        s_valid   = 1'b0;
        cfg_abort = 1'b0;
        repeat (cycles) @(negedge clk);
        check("rst_cfg_zero", 64'(config_bits), 64'd0);
        check("rst_fabric_low", 64'(fabric_rst_n), 64'd0);
        check("rst_not_ready", 64'(s_ready), 64'd0);
        rst = 1'b0;
        model_cfg = '0;
        measure_hold(1'b0, n, dones);
        check("post_rst_hold_len", 64'(n), 64'(RST_CYCLES));
        check("post_rst_ready", 64'(s_ready), 64'd1);
        check("post_rst_idle", 64'(cfg_busy), 64'd0);
        check("post_rst_cfg", 64'(config_bits), 64'd0);
    endtask

    task automatic random_frame(input bit corrupt);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            frm[i] = 8'($urandom);
            x = x ^ frm[i];
        end
        frm[NBYTES] = corrupt ? (x ^ 8'($urandom_range(1, 255))) : x;
    endtask

    // directed sequence
    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        cfg_abort = 1'b0;
        model_cfg = '0;

        // reset
        do_reset(3);

        // good frame, back-to-back
        frm = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00};
        send_frame(1'b0);
        finish_frame(1'b0);
        check("good_const", 64'(config_bits), 64'h7_0605_0403_0201);

        // bad checksum
        frm[NBYTES] = 8'hFF;
        send_frame(1'b0);
        finish_frame(1'b0);

        // throttled source with a top byte whose high nibble is dropped
        frm = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hF7, 8'h00};
        frm[NBYTES] = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'hF7;
        send_frame(1'b1);
        finish_frame(1'b0);
        check("top_nibble_dropped", 64'(config_bits[51:48]), 64'h7);

        // abort after three bytes (third consumed together with the abort)
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        cfg_abort = 1'b1;
        send_byte(8'hCC, 1'b0);
        cfg_abort = 1'b0;
        check("abort_clears_cnt", 64'(cfg_busy), 64'd0);
        random_frame(1'b0);
        send_frame(1'b0);
        finish_frame(1'b1);

        // abort landing in the CHECK cycle cancels the commit
        random_frame(1'b0);
        send_frame(1'b0);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        check("chk_abort_cfg", 64'(config_bits), 64'(model_cfg));
        check("chk_abort_no_done", 64'(cfg_done), 64'd0);
        check("chk_abort_no_err", 64'(cfg_err), 64'd0);
        check("chk_abort_ready", 64'(s_ready), 64'd1);

        // reset mid-frame
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
        do_reset(2);
        random_frame(1'b0);
        send_frame(1'b0);
        finish_frame(1'b0);

        // randomized frames
        for (int f = 0; f < 10; f++) begin
            random_frame($urandom_range(0, 2) == 0);
            send_frame(1'(($urandom_range(0, 1))));
            finish_frame(1'(($urandom_range(0, 1))));
        end

        check("done_count", 64'(done_seen), 64'(exp_done));
        check("err_count", 64'(err_seen), 64'(exp_err));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
